// File: rtl/synth_pkg.sv
// Shared types and constants for the voice scheduler and its per-voice envelope.
package synth_pkg;
    typedef enum logic [1:0] {V_IDLE, V_ATTACK, V_SUSTAIN, V_RELEASE} voice_state_t;

    localparam int              NOTE_W    = 4;
    localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd0;
    localparam int              NUM_NOTES = 13;
    localparam int              OCT_W     = 3;
endpackage

// File: rtl/voice_env.sv
// Per-voice envelope FSM: IDLE/ATTACK/SUSTAIN/RELEASE with saturating ramps on tick.
module voice_env
    import synth_pkg::*;
#(
    parameter int ENV_W    = 8,
    parameter int ATK_STEP = 16,
    parameter int REL_STEP = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             retrigger,
    input  logic             do_release,
    input  logic             tick,
    output voice_state_t     state,
    output logic [ENV_W-1:0] env
);
    localparam logic [ENV_W-1:0] ENV_MAX = {ENV_W{1'b1}};
    localparam logic [ENV_W:0]   ATK_INC = (ENV_W+1)'(ATK_STEP);
    localparam logic [ENV_W-1:0] REL_DEC = ENV_W'(REL_STEP);

    voice_state_t     state_nxt;
    logic [ENV_W-1:0] env_nxt;
    logic [ENV_W:0]   atk_sum;

    assign atk_sum = {1'b0, env} + ATK_INC;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= V_IDLE;
            env   <= '0;
        end else begin
            state <= state_nxt;
            env   <= env_nxt;
        end
    end

    // Allocation beats retrigger beats release beats the envelope tick.
    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        if (start) begin
            state_nxt = V_ATTACK;
            env_nxt   = '0;
        end else if (retrigger) begin
            state_nxt = V_ATTACK;
        end else if (do_release) begin
            state_nxt = V_RELEASE;
        end else if (tick) begin
            case (state)
                V_ATTACK: begin
                    if (atk_sum >= {1'b0, ENV_MAX}) begin
                        env_nxt   = ENV_MAX;
                        state_nxt = V_SUSTAIN;
                    end else begin
                        env_nxt = atk_sum[ENV_W-1:0];
                    end
                end
                V_RELEASE: begin
                    if (env <= REL_DEC) begin
                        env_nxt   = '0;
                        state_nxt = V_IDLE;
                    end else begin
                        env_nxt = env - REL_DEC;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/voice_scheduler.sv
// Maps held keypad notes onto persistent voice slots; owns octave and poly/mono mode.
// Define VOICE_STEAL_EN to let a new note steal the quietest RELEASE voice when none is IDLE.
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int ENV_W      = 8,
    parameter int ATK_STEP   = 16,
    parameter int REL_STEP   = 4,
    parameter int OCT_MAX    = 4,
    parameter int OCT_RESET  = 2
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic [NOTE_W-1:0]                  note_1,
    input  logic [NOTE_W-1:0]                  note_2,
    input  logic [NOTE_W-1:0]                  note_3,
    input  logic [NOTE_W-1:0]                  note_4,
    input  logic                               octave_pulse,
    input  logic                               mode_pulse,
    input  logic                               env_tick,
    output logic [NUM_VOICES-1:0][NOTE_W-1:0]  voice_note,
    output logic [NUM_VOICES-1:0][OCT_W-1:0]   voice_oct,
    output logic [NUM_VOICES-1:0][ENV_W-1:0]   voice_env,
    output logic [NUM_VOICES-1:0]              voice_active,
    output logic [OCT_W-1:0]                   octave,
    output logic                               mode
);
    localparam int NUM_REQ = 4;

    logic [OCT_W-1:0]                  oct_q;
    logic                              mode_q;
    logic [NUM_VOICES-1:0][NOTE_W-1:0] note_q;
    logic [NUM_VOICES-1:0][OCT_W-1:0]  voct_q;
    voice_state_t [NUM_VOICES-1:0]     vstate;
    logic [NUM_VOICES-1:0][ENV_W-1:0]  venv;
    logic [NUM_VOICES-1:0]             held, rel_st, idle, start, retrig, do_rel;
    logic [NUM_REQ-1:0][NOTE_W-1:0]    req;
    logic [NOTE_W-1:0]                 cand;

    // Mono listens to note_1 only; out-of-range codes count as no key.
    always_comb begin
        req[0] = note_1;
        req[1] = note_2;
        req[2] = note_3;
        req[3] = note_4;
        if (mode_q) begin
            for (int i = 1; i < NUM_REQ; i++) req[i] = NOTE_NONE;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] > NOTE_W'(NUM_NOTES)) req[i] = NOTE_NONE;
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            held[v]   = (vstate[v] == V_ATTACK) || (vstate[v] == V_SUSTAIN);
            rel_st[v] = (vstate[v] == V_RELEASE);
            idle[v]   = (vstate[v] == V_IDLE);
        end
    end

    always_comb begin
        logic wanted;
        wanted = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            wanted = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] != NOTE_NONE && req[i] == note_q[v]) wanted = 1'b1;
            end
            do_rel[v] = held[v] && (mode_pulse || !wanted);
        end
    end

    // Candidate: first requested note (note_1 first) not already sounding.
    always_comb begin
        logic taken;
        taken = 1'b0;
        cand  = NOTE_NONE;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            taken = 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (held[v] && note_q[v] == req[i]) taken = 1'b1;
            end
            if (req[i] != NOTE_NONE && !taken) cand = req[i];
        end
    end

`ifdef VOICE_STEAL_EN
    logic [NUM_VOICES-1:0] steal_pick;
    logic [ENV_W-1:0]      best_env;

    always_comb begin
        steal_pick = '0;
        best_env   = '1;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (rel_st[v] && (steal_pick == '0 || venv[v] < best_env)) begin
                steal_pick = NUM_VOICES'(1) << v;
                best_env   = venv[v];
            end
        end
    end
`endif

    always_comb begin
        logic [NUM_VOICES-1:0] rt_pick, idle_pick;
        rt_pick   = '0;
        idle_pick = '0;
        start     = '0;
        retrig    = '0;
        for (int v = NUM_VOICES-1; v >= 0; v--) begin
            if (rel_st[v] && note_q[v] == cand) rt_pick = NUM_VOICES'(1) << v;
            if (idle[v]) idle_pick = NUM_VOICES'(1) << v;
        end
        if (cand != NOTE_NONE && !mode_pulse) begin
            if (|rt_pick)        retrig = rt_pick;
            else if (|idle_pick) start  = idle_pick;
`ifdef VOICE_STEAL_EN
            else                 start  = steal_pick;
`endif
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            oct_q  <= OCT_W'(OCT_RESET);
            mode_q <= 1'b0;
            note_q <= '0;
            voct_q <= '0;
        end else begin
            if (octave_pulse) oct_q <= (oct_q == OCT_W'(OCT_MAX)) ? '0 : oct_q + 1'b1;
            if (mode_pulse)   mode_q <= ~mode_q;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (start[v]) begin
                    note_q[v] <= cand;
                    voct_q[v] <= oct_q;
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_env #(
            .ENV_W   (ENV_W),
            .ATK_STEP(ATK_STEP),
            .REL_STEP(REL_STEP)
        ) u_env (
            .clk       (clk),
            .nrst      (nrst),
            .start     (start[v]),
            .retrigger (retrig[v]),
            .do_release(do_rel[v]),
            .tick      (env_tick),
            .state     (vstate[v]),
            .env       (venv[v])
        );
        assign voice_note[v]   = idle[v] ? NOTE_NONE : note_q[v];
        assign voice_active[v] = !idle[v];
    end

    assign voice_env = venv;
    assign voice_oct = voct_q;
    assign octave    = oct_q;
    assign mode      = mode_q;
endmodule
